// File: rtl/alu_wb_stage.sv
// alu_wb_stage: ALU writeback/flags stage with a 2-entry result FIFO toward the register file.
// Optional zero/sign flag tracking is enabled by defining ALU_WB_ZFSF_EN.
module alu_wb_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_res,
  input  logic        in_cf,
  input  logic        in_af,
  input  logic        in_of,
  input  logic [1:0]  in_sel,
  input  logic [2:0]  in_dst,
  input  logic        flags_wr,
  input  logic [2:0]  flags_wdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [2:0]  wb_dst,
  output logic [2:0]  flags,
  output logic        zf,
  output logic        sf,
  output logic [1:0]  occupancy
);
  localparam logic [1:0] FULL = 2'(DEPTH);
  logic [31:0] mem_data [2];
  logic [2:0]  mem_dst [2];
  logic        rd_ptr, wr_ptr, rd_nxt;
  logic        accept, push, pop, is_add, new_head;
  logic [1:0]  occ_nxt;
  assign in_ready = occupancy != FULL;
  assign wb_valid = occupancy != 2'd0;
  always_comb begin
    accept   = in_valid && in_ready;
    push     = accept && (in_dst != 3'd0);
    pop      = wb_valid && wb_ready;
    is_add   = accept && (in_sel == 2'b11);
    occ_nxt  = occupancy + 2'(push) - 2'(pop);
    rd_nxt   = rd_ptr ^ pop;
    new_head = push && (wr_ptr == rd_nxt);
  end
  // wb_data/wb_dst are registered copies of whatever entry will be at the head next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy   <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      mem_data[0] <= '0;
      mem_data[1] <= '0;
      mem_dst[0]  <= '0;
      mem_dst[1]  <= '0;
      wb_data     <= '0;
      wb_dst      <= '0;
    end else begin
      occupancy <= occ_nxt;
      rd_ptr    <= rd_nxt;
      if (push) begin
        mem_data[wr_ptr] <= in_res;
        mem_dst[wr_ptr]  <= in_dst;
        wr_ptr           <= ~wr_ptr;
      end
      if (occ_nxt != 2'd0) begin
        wb_data <= new_head ? in_res : mem_data[rd_nxt];
        wb_dst  <= new_head ? in_dst : mem_dst[rd_nxt];
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags <= 3'b000;
    else if (flags_wr) flags <= flags_wdata;
    else if (is_add) flags <= {in_cf, in_af, in_of};
  end
`ifdef ALU_WB_ZFSF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zf <= 1'b0;
      sf <= 1'b0;
    end else if (is_add) begin
      zf <= in_res == 32'd0;
      sf <= in_res[31];
    end
  end
`else
  assign zf = 1'b0;
  assign sf = 1'b0;
`endif
endmodule

// File: tb/tb_alu_wb_stage.sv
// tb_alu_wb_stage: vector table, directed corner sequences and randomized run against a queue model.
module tb_alu_wb_stage;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, in_cf = 0, in_af = 0, in_of = 0, flags_wr = 0, wb_ready = 0;
  logic [31:0] in_res = 0;
  logic [1:0]  in_sel = 0;
  logic [2:0]  in_dst = 0, flags_wdata = 0;
  logic        in_ready, wb_valid, zf, sf;
  logic [31:0] wb_data;
  logic [2:0]  wb_dst, flags;
  logic [1:0]  occupancy;
  int compared = 0, mismatched = 0;
  logic [34:0] q[$];
  logic [2:0]  m_flags = 0;
  logic        m_zf = 0, m_sf = 0;

  alu_wb_stage #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res),
    .in_cf(in_cf), .in_af(in_af), .in_of(in_of), .in_sel(in_sel), .in_dst(in_dst),
    .flags_wr(flags_wr), .flags_wdata(flags_wdata), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_dst(wb_dst), .flags(flags), .zf(zf), .sf(sf), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] res,
                       input logic [2:0] cao, input logic [2:0] dst,
                       input logic fw, input logic [2:0] fwd, input logic rdy);
    in_valid = v; in_sel = sel; in_res = res; {in_cf, in_af, in_of} = cao; in_dst = dst;
    flags_wr = fw; flags_wdata = fwd; wb_ready = rdy;
  endtask

  task automatic model_reset();
    q.delete(); m_flags = 0; m_zf = 0; m_sf = 0;
  endtask

  // Compare outputs against the model, then advance model and DUT by one clock.
  task automatic step();
    bit acc;
    chk("in_ready", in_ready, q.size() < 2);
    chk("wb_valid", wb_valid, q.size() != 0);
    chk("occupancy", occupancy, q.size());
    chk("flags", flags, m_flags);
    chk("zf", zf, m_zf);
    chk("sf", sf, m_sf);
    if (q.size() != 0) begin
      chk("wb_data", wb_data, q[0][31:0]);
      chk("wb_dst", wb_dst, q[0][34:32]);
    end
    acc = in_valid && q.size() < 2;
    if (q.size() != 0 && wb_ready) void'(q.pop_front());
    if (acc && in_dst != 0) q.push_back({in_dst, in_res});
    if (flags_wr) m_flags = flags_wdata;
    else if (acc && in_sel == 2'b11) m_flags = {in_cf, in_af, in_of};
`ifdef ALU_WB_ZFSF_EN
    if (acc && in_sel == 2'b11) begin
      m_zf = in_res == 0;
      m_sf = in_res[31];
    end
`endif
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic v; logic [1:0] sel; logic [31:0] res; logic [2:0] cao; logic [2:0] dst;
    logic fw; logic [2:0] fwd; logic rdy;
    logic [1:0] e_occ; logic [31:0] e_data; logic [2:0] e_dst; logic [2:0] e_flags;
  } vec_t;
  vec_t vt[9];

  initial begin
    logic [31:0] held;
    vt[0] = '{1, 2'b11, 32'h0,        3'b110, 3'd3, 0, 3'b000, 0, 2'd1, 32'h0,  3'd3, 3'b110};
    vt[1] = '{0, 2'b00, 32'h0,        3'b000, 3'd0, 0, 3'b000, 1, 2'd0, 32'h0,  3'd0, 3'b110};
    vt[2] = '{1, 2'b11, 32'h5,        3'b111, 3'd1, 0, 3'b000, 0, 2'd1, 32'h5,  3'd1, 3'b111};
    vt[3] = '{1, 2'b01, 32'h7,        3'b000, 3'd2, 0, 3'b000, 0, 2'd2, 32'h5,  3'd1, 3'b111};
    vt[4] = '{0, 2'b00, 32'h0,        3'b000, 3'd0, 0, 3'b000, 1, 2'd1, 32'h7,  3'd2, 3'b111};
    vt[5] = '{0, 2'b00, 32'h0,        3'b000, 3'd0, 0, 3'b000, 1, 2'd0, 32'h0,  3'd0, 3'b111};
    vt[6] = '{1, 2'b11, 32'h8000_0009, 3'b110, 3'd5, 1, 3'b001, 0, 2'd1, 32'h8000_0009, 3'd5, 3'b001};
    vt[7] = '{0, 2'b00, 32'h0,        3'b000, 3'd0, 0, 3'b000, 1, 2'd0, 32'h0,  3'd0, 3'b001};
    vt[8] = '{1, 2'b11, 32'h1,        3'b100, 3'd0, 0, 3'b000, 1, 2'd0, 32'h0,  3'd0, 3'b100};

    @(negedge clk);
    @(negedge clk);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_flags", flags, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_dst", wb_dst, 0);
    rst = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    foreach (vt[i]) begin
      drive(vt[i].v, vt[i].sel, vt[i].res, vt[i].cao, vt[i].dst, vt[i].fw, vt[i].fwd, vt[i].rdy);
      step();
      chk($sformatf("vec%0d_occ", i), occupancy, vt[i].e_occ);
      chk($sformatf("vec%0d_flags", i), flags, vt[i].e_flags);
      if (vt[i].e_occ != 0) begin
        chk($sformatf("vec%0d_data", i), wb_data, vt[i].e_data);
        chk($sformatf("vec%0d_dst", i), wb_dst, vt[i].e_dst);
      end
`ifdef ALU_WB_ZFSF_EN
      if (i == 0) chk("vec0_zf", zf, 1);
`endif
    end

    // Stall: three back-to-back ops with the register file blocked.
    drive(1, 2'b01, 32'hA1, 3'b000, 3'd1, 0, 3'b000, 0); step();
    drive(1, 2'b01, 32'hA2, 3'b000, 3'd2, 0, 3'b000, 0); step();
    drive(1, 2'b01, 32'hA4, 3'b000, 3'd4, 0, 3'b000, 0);
    chk("stall_in_ready_low", in_ready, 0);
    held = wb_data;
    step(); step();
    chk("stall_data_stable", wb_data, held);
    chk("stall_head_dst", wb_dst, 1);
    wb_ready = 1;
    step();
    chk("drain_dst2", wb_dst, 2);
    step();
    in_valid = 0;
    chk("drain_dst4", wb_dst, 4);
    step();
    chk("drain_empty", occupancy, 0);

    // Flags-only add at full occupancy waits for a pop.
    drive(1, 2'b00, 32'hB1, 3'b000, 3'd6, 0, 3'b000, 0); step();
    drive(1, 2'b00, 32'hB2, 3'b000, 3'd7, 0, 3'b000, 0); step();
    drive(1, 2'b11, 32'h0, 3'b100, 3'd0, 0, 3'b000, 0);
    held = 32'(flags);
    step();
    chk("fonly_held_flags", flags, held);
    wb_ready = 1; step();
    wb_ready = 0; step();
    in_valid = 0;
    chk("fonly_flags", flags, 3'b100);
    chk("fonly_occ", occupancy, 1);
    wb_ready = 1; step(); step();

    // Asynchronous reset while stalled at full occupancy.
    drive(1, 2'b11, 32'hC1, 3'b111, 3'd1, 0, 3'b000, 0); step();
    drive(1, 2'b11, 32'hC2, 3'b111, 3'd2, 0, 3'b000, 0); step();
    chk("pre_rst_occ", occupancy, 2);
    #2 rst = 1;
    #1;
    chk("arst_wb_valid", wb_valid, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_flags", flags, 0);
    model_reset();
    in_valid = 0;
    @(negedge clk);
    rst = 0;
    wb_ready = 1;
    step(); step();
    chk("post_rst_no_stale", wb_valid, 0);

    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 9) < 7, 2'($urandom), $urandom, 3'($urandom), 3'($urandom),
            $urandom_range(0, 9) == 0, 3'($urandom), $urandom_range(0, 9) < 6);
      if (n % 97 == 5) in_res = (n % 2) ? 32'h0 : 32'h8000_0000;
      step();
    end
    in_valid = 0; flags_wr = 0; wb_ready = 1;
    step(); step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_wb_stage.md
# alu_wb_stage

Writeback/flags stage on the consumer side of the 32-bit ALU datapath. It accepts one ALU result per handshake together with the ALU's CF/AF/OF outputs, the op select and a destination tag. It commits the architectural flags register in acceptance order and buffers results in a 2-entry FIFO toward the register-file write port. It is the receiving end of the ALU's `out`/`cf`/`af`/`of` interface.

## Interface
Parameters:
- `DEPTH`, 2: writeback FIFO entries; only 2 is supported.

Ports:
- `clk`, in, 1: sole clock; all state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: the ALU result, flags, sel and dst are valid.
- `in_ready`, out, 1: stage can accept this cycle.
- `in_res`, in, 32: ALU `out`.
- `in_cf`, `in_af`, `in_of`, in, 1 each: ALU flag outputs.
- `in_sel`, in, 2: op select (00 pass-b, 01 or, 10 per, 11 add).
- `in_dst`, in, 3: destination register; 0 means no register writeback.
- `flags_wr`, in, 1: external flags load (flags-restore path).
- `flags_wdata`, in, 3: {CF, AF, OF} value to load.
- `wb_valid`, out, 1: FIFO head is valid.
- `wb_ready`, in, 1: register file accepts the head.
- `wb_data`, out, 32: head result.
- `wb_dst`, out, 3: head destination, never 0.
- `flags`, out, 3: architectural {CF, AF, OF}.
- `zf`, `sf`, out, 1 each: zero and sign flags; see Configuration.
- `occupancy`, out, 2: FIFO entry count, 0..2.

## Operation
- Accept when `in_valid && in_ready`. `in_ready = (occupancy != 2)`, independent of `in_dst` and `in_valid`. There is no combinational path from `wb_ready` to `in_ready`.
- On accept with `in_dst != 0`, push {`in_res`, `in_dst`} at the tail.
- On accept with `in_dst == 0` (flags-only op), update flags only and push nothing.
- On accept with `in_sel == 2'b11`, load `flags <= {in_cf, in_af, in_of}`.
- On accept with any other `in_sel`, leave `flags` unchanged. The ALU's forced zeros are ignored.
- If `flags_wr` is high, load `flags <= flags_wdata`. This has priority over a simultaneous add update in the same cycle, and the add's flags are discarded.
- Pop when `wb_valid && wb_ready`. `wb_data`/`wb_dst` always reflect the head entry and are held stable while `wb_valid && !wb_ready`.
- Simultaneous push and pop:
  - At occupancy 1: occupancy stays 1 and the head advances to the new entry.
  - At occupancy 2: the pop frees a slot, but `in_ready` was already low, so no push occurs.
- FIFO is circular with 1-bit read/write pointers. Pointers wrap 1 to 0; no other wrap state is kept.
- `wb_valid = (occupancy != 0)`.
- Reset values (asynchronous, immediate): `occupancy = 0`, `wb_valid = 0`, `in_ready = 1` after reset deasserts, `flags = 3'b000`, `zf = 0`, `sf = 0`, pointers 0, `wb_data`/`wb_dst` = 0.
- Reset mid-operation drops all buffered entries. No partial writeback is emitted.

## Timing
- Accept at edge N: the entry is visible on `wb_valid`/`wb_data` in cycle N+1, so latency is 1 cycle. There is no input-to-output bypass.
- Flags update at edge N and are visible on `flags` in cycle N+1.
- Throughput is 1 op/cycle when `wb_ready` is held high.
- With `wb_ready` low, 2 ops fill the FIFO and `in_ready` drops in the following cycle.
- All outputs are register-driven except `in_ready` and `wb_valid`, which are decodes of the `occupancy` register.

## Configuration
Macro `ALU_WB_ZFSF_EN`:
- Defined: on each accepted add, `zf <= (in_res == 0)` and `sf <= in_res[31]`. Non-add ops leave them unchanged, and `flags_wr` does not affect them.
- Undefined: `zf` and `sf` are tied to 0 and no related logic is generated.
- Port list is identical in both builds.

## Test plan
- Reset, then add with `in_res=32'h0000_0000`, `cf=1`, `af=1`, `of=0`, `dst=3`:
  - Cycle+1: `wb_valid=1`, `wb_data=0`, `wb_dst=3`, `flags=3'b110`.
  - With the macro defined: `zf=1`, `sf=0`.
- Add with flags 3'b111, then an or op with `cf/af/of=0`, `dst=2` -> `flags` remains 3'b111 and two entries drain in order.
- `wb_ready=0` with 3 back-to-back valid ops (dst 1, 2, 4):
  - `in_ready` goes low after the second accept and the third op is held.
  - Raising `wb_ready` drains dst 1, 2, 4 in order, with `wb_data` stable while stalled.
- Flags-only add (`dst=0`, `cf=1`) at `occupancy=2` -> not accepted until a pop. Once accepted, `flags` updates and `occupancy` is unchanged.
- Same-cycle `flags_wr=1`, `flags_wdata=3'b001` and an accepted add with flags 3'b110 -> `flags=3'b001`, and the add's result is still enqueued.
- Assert `rst` asynchronously at `occupancy=2` mid-stall -> `wb_valid`, `occupancy` and `flags` read 0 before the next clock edge, and no stale entry appears after release.
